// File: rtl/seg_pair_decoder.sv
// Reassembles scanned sign/magnitude seven-segment digits into frames, waits for
// STABLE_CNT identical frames in a row, then hands the decoded value out once.
`timescale 1ns/1ps
module seg_pair_decoder #(
   parameter int unsigned STABLE_CNT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       seg_valid,
   output logic       seg_ready,
   input  logic [7:0] seg_data,
   input  logic       seg_pos,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] num,
   output logic       err,
   output logic [7:0] err_cnt
);

   typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);

   state_t      state_q, state_d;
   logic        have_mag_q, have_mag_d;
   logic        have_sign_q, have_sign_d;
   logic [7:0]  mag_pat_q, mag_pat_d;
   logic [7:0]  sign_pat_q, sign_pat_d;
   logic [3:0]  stable_cnt_q, stable_cnt_d;
   logic [15:0] last_pair_q, last_pair_d;
   logic [3:0]  num_q, num_d;
   logic        err_q, err_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic [15:0] pair;
   logic [4:0]  dec;
   logic        xfer;

   // Returns {err, num}; every bit of both patterns must match, so a lit dp is illegal.
   function automatic logic [4:0] decode(input logic [15:0] p);
      logic [3:0] mag;
      logic [3:0] neg;
      logic       mag_ok;
      mag_ok = 1'b1;
      mag    = 4'd0;
      case (p[7:0])
         8'h03: mag = 4'd0;
         8'h9F: mag = 4'd1;
         8'h25: mag = 4'd2;
         8'h0D: mag = 4'd3;
         8'h99: mag = 4'd4;
         8'h49: mag = 4'd5;
         8'h41: mag = 4'd6;
         8'h1F: mag = 4'd7;
         8'h01: mag = 4'd8;
         8'h09: mag = 4'd9;
         default: mag_ok = 1'b0;
      endcase
      neg = ~mag + 4'd1;
      if (mag_ok && p[15:8] == 8'hFF && mag <= 4'd7)
         decode = {1'b0, mag};
      else if (mag_ok && p[15:8] == 8'hFD && mag >= 4'd1 && mag <= 4'd8)
         decode = {1'b0, neg};
      else
         decode = 5'b1_0000;
   endfunction

   always_comb begin
      state_d      = state_q;
      have_mag_d   = have_mag_q;
      have_sign_d  = have_sign_q;
      mag_pat_d    = mag_pat_q;
      sign_pat_d   = sign_pat_q;
      stable_cnt_d = stable_cnt_q;
      last_pair_d  = last_pair_q;
      num_d        = num_q;
      err_d        = err_q;
      err_cnt_d    = err_cnt_q;
      seg_ready    = (state_q == COLLECT);
      out_valid    = (state_q == EMIT);
      xfer         = seg_valid && seg_ready;

      if (xfer) begin
         if (seg_pos) begin
            sign_pat_d  = seg_data;
            have_sign_d = 1'b1;
         end else begin
            mag_pat_d  = seg_data;
            have_mag_d = 1'b1;
         end
      end

      pair = {sign_pat_d, mag_pat_d};
      dec  = decode(pair);

      if (xfer && have_mag_d && have_sign_d) begin
         have_mag_d  = 1'b0;
         have_sign_d = 1'b0;
         if (pair == last_pair_q) begin
            if (stable_cnt_q != STABLE_MAX)
               stable_cnt_d = stable_cnt_q + 4'd1;
         end else begin
            last_pair_d  = pair;
            stable_cnt_d = 4'd1;
         end
         // Emit only on the frame that reaches the threshold, not on later repeats.
         if (stable_cnt_d == STABLE_MAX && !(pair == last_pair_q && stable_cnt_q == STABLE_MAX)) begin
            num_d   = dec[3:0];
            err_d   = dec[4];
            state_d = EMIT;
         end
      end

      if (state_q == EMIT && out_ready) begin
         state_d = COLLECT;
         if (err_q && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         have_mag_q   <= 1'b0;
         have_sign_q  <= 1'b0;
         mag_pat_q    <= 8'h00;
         sign_pat_q   <= 8'h00;
         stable_cnt_q <= 4'd0;
         last_pair_q  <= 16'h0000;
         num_q        <= 4'd0;
         err_q        <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         have_mag_q   <= have_mag_d;
         have_sign_q  <= have_sign_d;
         mag_pat_q    <= mag_pat_d;
         sign_pat_q   <= sign_pat_d;
         stable_cnt_q <= stable_cnt_d;
         last_pair_q  <= last_pair_d;
         num_q        <= num_d;
         err_q        <= err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign num     = num_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seg_pair_decoder.sv
// Directed bench for seg_pair_decoder: digit driver, output monitor with an
// expected queue of {err, num}, and a single summary line.
`timescale 1ns/1ps
module tb_seg_pair_decoder;

   logic       clk;
   logic       rst_n;
   logic       seg_valid;
   logic       seg_ready;
   logic [7:0] seg_data;
   logic       seg_pos;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] num;
   logic       err;
   logic [7:0] err_cnt;

   int errors = 0;
   int checks = 0;
   int emit_cnt = 0;
   int saved;
   logic [4:0] exp_q[$];

   seg_pair_decoder #(.STABLE_CNT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .seg_valid(seg_valid), .seg_ready(seg_ready),
      .seg_data(seg_data), .seg_pos(seg_pos),
      .out_valid(out_valid), .out_ready(out_ready),
      .num(num), .err(err), .err_cnt(err_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: outputs are sampled on the falling edge; inputs only change just after the rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         emit_cnt++;
         if (exp_q.size() == 0)
            check_eq("unexpected_out", {11'd0, err, num}, 16'hFFFF);
         else
            check_eq("out", {11'd0, err, num}, {11'd0, exp_q.pop_front()});
      end
   end

   // driver tasks: called at (rising edge + 1), return at (rising edge + 1)
   task automatic send_digit(input logic pos, input logic [7:0] data);
      int n;
      n = 0;
      seg_valid = 1'b1;
      seg_pos   = pos;
      seg_data  = data;
      @(negedge clk);
      while (!seg_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!seg_ready) check_eq("digit_timeout", 16'd0, 16'd1);
      @(posedge clk);
      #1;
      seg_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] sign, input logic [7:0] mag, input logic sign_first);
      if (sign_first) begin
         send_digit(1'b1, sign);
         send_digit(1'b0, mag);
      end else begin
         send_digit(1'b0, mag);
         send_digit(1'b1, sign);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (out_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (out_valid) check_eq("idle_timeout", 16'd1, 16'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check_eq("rst_err_cnt", {8'd0, err_cnt}, 16'd0);
      check_eq("rst_num_err", {11'd0, err, num}, 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; seg_valid = 1'b0; seg_data = 8'h00; seg_pos = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("reset_seg_ready", {15'd0, seg_ready}, 16'd1);
      check_eq("reset_out_valid", {15'd0, out_valid}, 16'd0);
      check_eq("reset_num_err", {11'd0, err, num}, 16'd0);
      check_eq("reset_err_cnt", {8'd0, err_cnt}, 16'd0);

      // +7 needs two identical frames, emits one cycle after the second completes
      send_frame(8'hFF, 8'h1F, 1'b1);
      check_eq("p7_first_no_out", {15'd0, out_valid}, 16'd0);
      send_frame(8'hFF, 8'h1F, 1'b1);
      check_eq("p7_latency", {15'd0, out_valid}, 16'd1);
      check_eq("p7_value", {11'd0, err, num}, 16'h0007);
      exp_q.push_back(5'h07);
      wait_idle();
      saved = emit_cnt;
      send_frame(8'hFF, 8'h1F, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("p7_third_silent", 16'(emit_cnt), 16'(saved));

      // negatives, magnitude first
      send_frame(8'hFD, 8'h01, 1'b0);
      send_frame(8'hFD, 8'h01, 1'b0);
      exp_q.push_back(5'h08);
      wait_idle();
      send_frame(8'hFD, 8'h9F, 1'b1);
      send_frame(8'hFD, 8'h9F, 1'b1);
      exp_q.push_back(5'h0F);
      wait_idle();

      // A, B, A restart the count; a fourth A emits 2
      saved = emit_cnt;
      send_frame(8'hFF, 8'h25, 1'b1);
      send_frame(8'hFF, 8'h49, 1'b1);
      send_frame(8'hFF, 8'h25, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check_eq("aba_silent", 16'(emit_cnt), 16'(saved));
      send_frame(8'hFF, 8'h25, 1'b1);
      exp_q.push_back(5'h02);
      wait_idle();

      // illegal frames
      send_frame(8'hFD, 8'h03, 1'b1); send_frame(8'hFD, 8'h03, 1'b1);
      exp_q.push_back(5'h10); wait_idle();
      check_eq("err_cnt_1", {8'd0, err_cnt}, 16'd1);
      send_frame(8'hFF, 8'h09, 1'b1); send_frame(8'hFF, 8'h09, 1'b1);
      exp_q.push_back(5'h10); wait_idle();
      check_eq("err_cnt_2", {8'd0, err_cnt}, 16'd2);
      send_frame(8'hFF, 8'h02, 1'b0); send_frame(8'hFF, 8'h02, 1'b0);
      exp_q.push_back(5'h10); wait_idle();
      check_eq("err_cnt_3", {8'd0, err_cnt}, 16'd3);
      send_frame(8'hAA, 8'h03, 1'b1); send_frame(8'hAA, 8'h03, 1'b1);
      exp_q.push_back(5'h10); wait_idle();
      check_eq("err_cnt_4", {8'd0, err_cnt}, 16'd4);

      // saturation: alternate two illegal frames so each pair emits
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) begin
            send_frame(8'hFD, 8'h03, 1'b1); send_frame(8'hFD, 8'h03, 1'b1);
         end else begin
            send_frame(8'hFF, 8'h09, 1'b1); send_frame(8'hFF, 8'h09, 1'b1);
         end
         exp_q.push_back(5'h10);
         wait_idle();
         if (i == 250) check_eq("err_cnt_255", {8'd0, err_cnt}, 16'd255);
      end
      check_eq("err_cnt_sat", {8'd0, err_cnt}, 16'd255);

      // backpressure: digit held during EMIT is stalled, then taken after the handshake
      out_ready = 1'b0;
      send_frame(8'hFF, 8'h0D, 1'b1);
      send_frame(8'hFF, 8'h0D, 1'b1);
      exp_q.push_back(5'h03);
      seg_valid = 1'b1; seg_pos = 1'b0; seg_data = 8'h99;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_seg_ready", {15'd0, seg_ready}, 16'd0);
         check_eq("bp_out_valid", {15'd0, out_valid}, 16'd1);
         check_eq("bp_value", {11'd0, err, num}, 16'h0003);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_drop", {15'd0, out_valid}, 16'd0);
      check_eq("bp_ready_back", {15'd0, seg_ready}, 16'd1);
      @(posedge clk);
      #1;
      seg_valid = 1'b0;
      send_digit(1'b1, 8'hFF);
      check_eq("bp_frame1_silent", {15'd0, out_valid}, 16'd0);
      send_frame(8'hFF, 8'h99, 1'b1);
      exp_q.push_back(5'h04);
      wait_idle();

      // async reset during EMIT, then after a half frame
      out_ready = 1'b0;
      send_frame(8'hFF, 8'h0D, 1'b1);
      send_frame(8'hFF, 8'h0D, 1'b1);
      check_eq("pre_rst_emit", {15'd0, out_valid}, 16'd1);
      pulse_reset();
      out_ready = 1'b1;
      send_digit(1'b0, 8'h0D);
      pulse_reset();
      saved = emit_cnt;
      send_digit(1'b1, 8'hFF);
      send_frame(8'hFF, 8'h0D, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check_eq("half_frame_discarded", 16'(emit_cnt), 16'(saved));
      send_frame(8'hFF, 8'h0D, 1'b1);
      exp_q.push_back(5'h03);
      wait_idle();

      check_eq("exp_q_drained", 16'(exp_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_pair_decoder.md
Name: seg_pair_decoder

Overview:
- Inverse of the two-digit seven-segment encoder.
- Accepts scanned segment patterns (sign digit plus magnitude digit) one digit per transfer, reassembles each frame, and filters glitchy frames with a stability count.
- Decodes a stable frame back to a 4-bit two's-complement number.
- Sits between the display-scan tap (or a loopback of the encoder outputs) and checking/host logic; emits each stable value once over a valid/ready handshake.

Parameters:
- STABLE_CNT, 2, number of consecutive identical frames required before a value is emitted. Legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_valid  input  1  a digit pattern is offered.
- seg_ready  output  1  block can accept a digit.
- seg_data  input  8  active-low pattern; bit7..bit1 = segments a..g, bit0 = dp.
- seg_pos  input  1  0 = magnitude digit, 1 = sign digit.
- out_valid  output  1  decoded frame is available.
- out_ready  input  1  consumer accepts the frame.
- num  output  4  decoded two's-complement value; 0 when err=1.
- err  output  1  decoded frame was illegal.
- err_cnt  output  8  count of emitted error frames, saturating at 255.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=COLLECT, have_mag=0, have_sign=0, stable_cnt=0, last_pair=16'h0000.
  - out_valid=0, num=0, err=0, err_cnt=0. seg_ready=1 once reset is released.
  - Reset mid-frame or mid-EMIT discards everything, including an unaccepted output.
- Digit transfer occurs when seg_valid && seg_ready.
  - seg_ready = (state==COLLECT).
  - A transfer stores seg_data in the mag_pat or sign_pat register selected by seg_pos, and sets the matching have_ flag.
  - A repeated position before the frame completes overwrites the earlier pattern.
  - The two digits may arrive in either order.
- Frame completion: the transfer that makes have_mag && have_sign true, using the incoming byte directly.
  - Both flags clear in the same cycle.
  - pair={sign_pat,mag_pat}.
  - If pair==last_pair: stable_cnt increments, saturating at STABLE_CNT. Otherwise last_pair<=pair and stable_cnt<=1.
  - When stable_cnt becomes exactly STABLE_CNT in this cycle, num and err are registered from pair and state<=EMIT.
  - Further identical frames, with stable_cnt already saturated, emit nothing. A differing frame restarts the count at 1.
  - With STABLE_CNT=1, every changed frame emits.
- Decode (all 8 bits compared):
  - Magnitude patterns:
    - 0=0x03, 1=0x9F, 2=0x25, 3=0x0D, 4=0x99
    - 5=0x49, 6=0x41, 7=0x1F, 8=0x01, 9=0x09
  - Sign patterns: 0xFF = positive, 0xFD = negative.
  - Positive with mag 0..7 gives num=mag. Negative with mag 1..8 gives num=(~mag+1)[3:0]; 8 maps to 4'b1000.
  - Everything else sets err=1, num=0. This covers an unknown magnitude pattern, an unknown sign pattern, dp lit, positive 8/9, negative 0 and negative 9.
- EMIT state:
  - out_valid=1, seg_ready=0.
  - num and err stay stable until out_ready is high at a clock edge; then out_valid<=0 and state<=COLLECT.
  - err_cnt increments, saturating at 255, on acceptance of a frame with err=1.
- Latency: completing transfer at edge N gives out_valid=1 after edge N. The earliest next digit is accepted at the edge after the output handshake.
- seg_valid held during EMIT is stalled, not dropped.
- out_ready while out_valid=0 has no effect.

Test Plan:
- STABLE_CNT=2. Send {pos1:0xFF, pos0:0x1F} twice -> one output num=4'd7, err=0, one cycle after the second completion. A third identical frame -> no output.
- STABLE_CNT=2. Send sign 0xFD, magnitude 0x01 (either order), twice -> num=4'b1000, err=0. Then magnitude 0x9F with sign 0xFD, twice -> num=4'b1111.
- Send frame A (0xFF/0x25), then B (0xFF/0x49), then A -> no output, since the count restarts at 1 each time. Send A again -> num=2.
- Illegal frames (0xFD/0x03, 0xFF/0x09, 0xFF/0x02, 0xAA/0x03), each stabilised -> err=1, num=0; err_cnt increments 1,2,3,4 on acceptance. Drive 300 errors -> err_cnt holds at 255.
- Backpressure: hold out_ready=0 for 5 cycles with seg_valid=1 -> seg_ready=0, num/err stable. Raise out_ready -> out_valid drops next edge, and the pending digit is accepted on the following edge.
- Assert rst_n low asynchronously during EMIT and after a half frame -> out_valid=0 and err_cnt=0 immediately. After release, the half frame is not completed by a single digit.
